// File: rtl/dtc_pkg.sv
// ============================================================================
// Module  : dtc_pkg
// Purpose : Shared widths, types and state encoding for the witness search.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package dtc_pkg;

    localparam int DTC_IN_W  = 12;
    localparam int DTC_CLS_W = 3;

    typedef logic [DTC_IN_W-1:0]  feat_t;
    typedef logic [DTC_CLS_W-1:0] cls_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } dtc_ws_state_e;

endpackage

`default_nettype wire

// File: rtl/dtc_skid1.sv
// ============================================================================
// Module  : dtc_skid1
// Purpose : One-entry valid/ready output register; capture and transfer may
//           happen on the same edge for full throughput.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module dtc_skid1
    import dtc_pkg::*;
#(
    parameter int W = DTC_IN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         slot_free_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign slot_free_o = !valid_q || ready_i;
    assign valid_o     = valid_q;
    assign data_o      = data_q;

    // Capture is only requested by the parent when the slot is free, so a
    // capture implicitly covers any transfer happening on the same edge.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dtc_witness_search.sv
// ============================================================================
// Module  : dtc_witness_search
// Purpose : Sweeps every feature vector through an external classifier and
//           streams out the vectors that classify to the target class.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module dtc_witness_search
    import dtc_pkg::*;
#(
    parameter int IN_W  = DTC_IN_W,
    parameter int CLS_W = DTC_CLS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CLS_W-1:0] target_i,
    output logic [IN_W-1:0]  feat_o,
    input  logic [CLS_W-1:0] class_i,
    output logic             wit_valid_o,
    input  logic             wit_ready_i,
    output logic [IN_W-1:0]  wit_data_o,
    output logic [IN_W:0]    hit_cnt_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [IN_W-1:0] FEAT_LAST = '1;
    localparam logic [IN_W-1:0] FEAT_ONE  = 1;
    localparam logic [IN_W:0]   HIT_ONE   = 1;

    dtc_ws_state_e    state_q, state_d;
    logic [IN_W-1:0]  feat_q, feat_d;
    logic [IN_W:0]    hit_q, hit_d;
    logic [CLS_W-1:0] tgt_q, tgt_d;
    logic             done_q, done_d;
    logic             busy_q;

    logic             capture;
    logic             flush;
    logic             slot_free;
    logic             match;

    assign match = (class_i == tgt_q);

    always_comb begin
        state_d = state_q;
        feat_d  = feat_q;
        hit_d   = hit_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        capture = 1'b0;
        flush   = 1'b0;
        if (abort_i) begin
            // Abort dominates everything, including a start in IDLE.
            state_d = IDLE;
            flush   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        tgt_d   = target_i;
                        feat_d  = '0;
                        hit_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (!(match && !slot_free)) begin
                        if (match) begin
                            capture = 1'b1;
                            hit_d   = hit_q + HIT_ONE;
                        end
                        if (feat_q == FEAT_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            feat_d = feat_q + FEAT_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (!wit_valid_o || wit_ready_i) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            feat_q  <= '0;
            hit_q   <= '0;
            tgt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            feat_q  <= feat_d;
            hit_q   <= hit_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    dtc_skid1 #(
        .W (IN_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (capture),
        .flush_i     (flush),
        .data_i      (feat_q),
        .ready_i     (wit_ready_i),
        .valid_o     (wit_valid_o),
        .data_o      (wit_data_o),
        .slot_free_o (slot_free)
    );

    assign feat_o    = feat_q;
    assign hit_cnt_o = hit_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dtc_witness_search.sv
// ============================================================================
// Module  : tb_dtc_witness_search
// Purpose : Scoreboard bench for dtc_witness_search with a model classifier.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_dtc_witness_search;
    import dtc_pkg::*;

    localparam int IN_W = DTC_IN_W;
    localparam int NV   = 1 << IN_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        abort_i;
    cls_t        target_i;
    feat_t       feat_o;
    cls_t        class_i;
    logic        wit_valid_o;
    logic        wit_ready_i;
    feat_t       wit_data_o;
    logic [IN_W:0] hit_cnt_o;
    logic        busy_o;
    logic        done_o;

    int    n_cmp = 0;
    int    n_mis = 0;
    int    cls_mode = 0;   // 0: feat[2:0], 1: const 0, 2: tied to target, 3: random LUT
    cls_t  tgt_m = '0;
    cls_t  lut [NV];
    int    rdy_mode = 0;   // 0: always, 1: random, 2: 20-cycle stall, 3: manual
    int    stall_left = 0;
    bit    stall_used = 0;
    int    exp_hits = 0;
    int    done_cnt = 0;
    int    val_cnt = 0;
    int    exp_q[$];
    bit    hold_pend = 0;
    feat_t hold_data = '0;

    dtc_witness_search dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .target_i    (target_i),
        .feat_o      (feat_o),
        .class_i     (class_i),
        .wit_valid_o (wit_valid_o),
        .wit_ready_i (wit_ready_i),
        .wit_data_o  (wit_data_o),
        .hit_cnt_o   (hit_cnt_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (cls_mode)
            0:       class_i = feat_o[2:0];
            1:       class_i = '0;
            2:       class_i = tgt_m;
            default: class_i = lut[feat_o];
        endcase
    end

    function automatic cls_t cls_of(input int v);
        feat_t f;
        f = feat_t'(v);
        case (cls_mode)
            0:       return f[2:0];
            1:       return '0;
            2:       return tgt_m;
            default: return lut[v];
        endcase
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Ready driver: changes only just after a rising edge.
    initial begin
        wit_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: wit_ready_i = 1'b1;
                1: wit_ready_i = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall_left > 0) begin
                        stall_left--;
                        wit_ready_i = (stall_left == 0);
                    end else if (!stall_used && wit_valid_o) begin
                        stall_used  = 1;
                        stall_left  = 20;
                        wit_ready_i = 1'b0;
                    end else begin
                        wit_ready_i = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Monitor: a transfer seen here completes on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 0;
        end else begin
            if (done_o) done_cnt++;
            if (wit_valid_o) val_cnt++;
            if (hold_pend) begin
                chk("hold_valid", wit_valid_o, 1);
                chk("hold_data", wit_data_o, hold_data);
            end
            if (wit_valid_o && wit_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL witness: got 0x%0h, expected none", wit_data_o);
                end else begin
                    chk("witness", wit_data_o, exp_q.pop_front());
                end
            end
            hold_pend = wit_valid_o && !wit_ready_i && !abort_i;
            hold_data = wit_data_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic start_sweep(input int cm, input cls_t tg);
        cls_mode = cm;
        tgt_m    = tg;
        exp_q.delete();
        exp_hits = 0;
        for (int v = 0; v < NV; v++) begin
            if (cls_of(v) == tg) begin
                exp_q.push_back(v);
                exp_hits++;
            end
        end
        done_cnt = 0;
        val_cnt  = 0;
        target_i = tg;
        start_i  = 1'b1;
        tick(1);
        start_i  = 1'b0;
        target_i = ~tg;
    endtask

    task automatic wait_done(input bit check_lat);
        int cyc;
        bit got;
        cyc = 0;
        got = 0;
        while (cyc < 20000) begin
            tick(1);
            cyc++;
            if (done_o) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", got, 1);
        if (check_lat) chk("done_latency", cyc, NV + 1);
        chk("hit_cnt", hit_cnt_o, exp_hits);
        chk("witnesses_left", exp_q.size(), 0);
        tick(3);
        chk("done_pulses", done_cnt, 1);
        chk("busy_after_done", busy_o, 0);
        chk("hit_cnt_hold", hit_cnt_o, exp_hits);
    endtask

    task automatic wait_feat(input int f);
        int cyc;
        cyc = 0;
        while (feat_o != feat_t'(f) && cyc < 10000) begin
            tick(1);
            cyc++;
        end
        chk("reach_feat", feat_o, f);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_feat"}, feat_o, 0);
        chk({tag, "_valid"}, wit_valid_o, 0);
        chk({tag, "_data"}, wit_data_o, 0);
        chk({tag, "_hits"}, hit_cnt_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
    endtask

    initial begin
        int f;
        int cyc;
        rst      = 1'b1;
        start_i  = 1'b0;
        abort_i  = 1'b0;
        target_i = '0;
        tick(3);
        chk_zero("reset");
        rst = 1'b0;
        tick(1);

        // Abort beats a simultaneous start in IDLE.
        start_i = 1'b1;
        abort_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        abort_i = 1'b0;
        tick(1);
        chk("start_abort_busy", busy_o, 0);

        // Basic sweep, target 5, always ready.
        rdy_mode = 0;
        start_sweep(0, 3'b101);
        wait_done(1);

        // Consumer stalls for 20 cycles on the first witness.
        rdy_mode   = 2;
        stall_used = 0;
        start_sweep(0, 3'b101);
        cyc = 0;
        while (!wit_valid_o && cyc < 100) begin
            tick(1);
            cyc++;
        end
        chk("stall_first_data", wit_data_o, 12'h005);
        tick(15);
        chk("stall_feat", feat_o, 12'h00D);
        chk("stall_data", wit_data_o, 12'h005);
        chk("stall_valid", wit_valid_o, 1);
        wait_done(0);
        chk("stall_hits", hit_cnt_o, 512);

        // No vector matches.
        rdy_mode = 0;
        start_sweep(1, 3'b111);
        wait_done(1);
        chk("never_valid", val_cnt, 0);

        // Every vector matches: full-width counter and last witness in DRAIN.
        start_sweep(2, 3'b010);
        wait_done(1);
        chk("all_hits", hit_cnt_o, NV);

        // Abort with a witness pending while stalled at 0x300.
        rdy_mode    = 3;
        wit_ready_i = 1'b1;
        start_sweep(0, 3'b000);
        wait_feat(12'h2F9);
        wit_ready_i = 1'b0;
        tick(10);
        chk("abort_pre_feat", feat_o, 12'h300);
        chk("abort_pre_valid", wit_valid_o, 1);
        chk("abort_pre_data", wit_data_o, 12'h2F8);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_valid", wit_valid_o, 0);
        chk("abort_hits", hit_cnt_o, 96);
        chk("abort_feat", feat_o, 12'h300);
        tick(3);
        chk("abort_no_done", done_cnt, 0);
        exp_q.delete();
        wit_ready_i = 1'b1;
        rdy_mode    = 0;
        start_sweep(0, 3'b000);
        chk("resweep_hits_clear", hit_cnt_o, 0);
        chk("resweep_feat", feat_o, 0);
        wait_done(1);

        // start_i ignored mid-sweep, then asynchronous reset mid-SCAN.
        start_sweep(0, 3'b101);
        tick(100);
        f = int'(feat_o);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(4);
        chk("start_ignored_feat", feat_o, f + 5);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        exp_q.delete();
        tick(1);
        rst = 1'b0;
        tick(1);

        // Randomized classifier, target and backpressure.
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < NV; v++) lut[v] = cls_t'($urandom_range(0, 7));
            rdy_mode = 1;
            start_sweep(3, cls_t'($urandom_range(0, 7)));
            wait_done(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
